// File: rtl/rrarb_lock.sv
// Registered round-robin arbiter that locks the grant for a multi-beat transfer, releasing on the
// last beat, a beat cap or a requester abort, then re-arbitrating the same cycle with no bubble.
module rrarb_lock #(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ),
  localparam int unsigned CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic               gnt_ready,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   rr_ptr
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;

  logic busy, win_req, accept, last, done;

  // Modulo-NUM_REQ increment, correct for non-power-of-two requester counts.
  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] sel(input logic [NUM_REQ-1:0] vec,
                                           input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] res;
    logic             found;
    idx   = base;
    res   = base;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && vec[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = inc_idx(idx);
    end
    return res;
  endfunction

  assign busy    = (state_q == StBusy);
  assign win_req = req[idx_q];
  assign accept  = busy & gnt_ready & win_req;
  assign last    = req_last[idx_q] | (cnt_q == CNT_W'(MAX_BEATS - 1));
  // A dropped request aborts the grant; that cycle's beat is not counted.
  assign done    = (accept & last) | (busy & ~win_req);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (|req) begin
        state_d = StBusy;
        idx_d   = sel(req, ptr_q);
        cnt_d   = '0;
      end
    end else if (done) begin
      ptr_d = inc_idx(idx_q);
      cnt_d = '0;
      if (|req) begin
        idx_d = sel(req, inc_idx(idx_q));
      end else begin
        state_d = StIdle;
      end
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
    onehot_d = (state_d == StBusy) ? (NUM_REQ'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  assign gnt_valid  = busy;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;
  assign rr_ptr     = ptr_q;

endmodule

// File: doc/rrarb_lock.md
# rrarb_lock

Parametrised, registered round-robin arbiter with transfer locking for the PIM request fabric. It selects one of NUM_REQ requesters by searching upward with wrap-around, starting from a rotating base pointer. It then holds the grant until the winner finishes a multi-beat transfer or hits a beat cap, and advances the pointer past the winner. It sits between per-channel request queues and a shared single-port resource, such as a bank command slot or a result bus, with a valid/ready handshake toward that resource.

## Interface
- NUM_REQ, 8, number of requesters; must be at least 2; need not be a power of two.
- MAX_BEATS, 16, maximum accepted beats per grant; must be at least 1.
- IDX_W, $clog2(NUM_REQ), derived; do not override.
- CNT_W, $clog2(MAX_BEATS), derived beat-counter width (minimum 1).
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held high for the whole transfer.
- req_last  in  NUM_REQ  per-requester flag; marks the current beat as the final beat.
- gnt_ready  in  1  downstream accepts the current beat.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  IDX_W  index of the granted requester.
- gnt_onehot  out  NUM_REQ  one-hot form of gnt_idx; all zero when gnt_valid=0.
- rr_ptr  out  IDX_W  current search base, for debug and performance counters.

## Operation
- Two states:
  - IDLE: gnt_valid=0.
  - BUSY: gnt_valid=1, and gnt_idx, gnt_onehot and beat_cnt are registered.
- Selection function SEL(vec, base): the first index i with vec[i]=1, scanning base, base+1, …, NUM_REQ-1, 0, …, base-1. All index arithmetic is modulo NUM_REQ; index NUM_REQ-1 plus 1 wraps to 0, including for non-power-of-two NUM_REQ.
- Definitions:
  - accept = gnt_valid & gnt_ready & req[gnt_idx].
  - last = req_last[gnt_idx] | (beat_cnt == MAX_BEATS-1).
  - done = (accept & last) | (gnt_valid & ~req[gnt_idx]).
- The second term of done is an abort: the winner dropped its request. The beat is not counted and gnt_ready is ignored.
- IDLE transitions:
  - If |req: register gnt_idx = SEL(req, rr_ptr), set beat_cnt=0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY transitions:
  - On accept & ~last: beat_cnt increments; the grant holds.
  - On done: rr_ptr <= gnt_idx+1 (mod NUM_REQ) and beat_cnt <= 0.
    - If |req, also register gnt_idx = SEL(req, gnt_idx+1) in the same cycle and stay in BUSY. This gives back-to-back grants with no bubble.
    - Otherwise go to IDLE.
  - While not done, gnt_idx, gnt_onehot and rr_ptr are stable. Changes to other req bits are ignored.
- The finishing requester may win again only when it is the sole active request, because it sits last in the search order.
- rr_ptr changes only on done. It does not change on IDLE→BUSY.

## Timing
- Reset values: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, rr_ptr=0, beat_cnt=0. An asynchronous assert mid-transfer drops the grant immediately; there is no completion and no pointer update.
- Request-to-grant latency:
  - req rising in IDLE at edge t gives gnt_valid=1 after edge t+1.
  - At completion, the next grant is visible on the cycle after the done edge.
- All outputs are registered. There is no combinational path from req, req_last or gnt_ready to any output.
- Handshake:
  - A beat transfers on every cycle where accept=1.
  - Downstream may hold gnt_ready low indefinitely; the grant persists.
  - The requester must keep req high until its last beat is accepted.
- Beat cap: after MAX_BEATS accepts, done fires on the MAX_BEATS-th accept whatever req_last says. With MAX_BEATS=1 every grant is a single beat.
- Simultaneous events:
  - abort and accept cannot coincide, since accept requires req[gnt_idx].
  - done together with new requests: the new requests take part in that cycle's re-arbitration.

## Test plan
- Single beat, NUM_REQ=8: req=8'h01 with req_last=1 and gnt_ready=1 -> gnt_idx=0 one cycle later, then rr_ptr=1, then IDLE.
- Fairness: req=8'hFF held, every beat last, gnt_ready=1 -> gnt_idx sequence 0,1,…,7,0 with no idle cycles.
- Lock with backpressure: req=8'h82 from IDLE, rr_ptr=0 -> grant 1. Hold for 3 beats with gnt_ready toggling 1,0,1,1 and last on beat 3 -> gnt_idx stays 1 throughout, then grants 7, and rr_ptr becomes 2.
- Beat cap with MAX_BEATS=4: requester 5 never asserts req_last -> released after exactly 4 accepts, and rr_ptr=6.
- Abort and wrap, NUM_REQ=5: grant 4 active, requester 4 drops req while req[0]=1 -> next grant 0, rr_ptr=0, and beat_cnt is unchanged by the abort.
- Reset mid-transfer: rst_n low during a grant -> all outputs zero immediately. After release with req=8'h10 -> grant 4.
